alu_controller: RTL and testbench

ALU_CONTROLLER -- requirements
Module: alu_controller

---
 rtl/alu_controller_if.sv | 31 +++
 rtl/alu_controller.sv | 108 ++++++++++
 tb/tb_alu_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_controller_if.sv
// alu_controller_if
//   Groups the ALU-control decode inputs and the registered one-hot
//   operation select into one bundle.
//   Signals:
//     ALUControl [4:0]  one-hot instruction-class select from the main decoder
//     func3      [2:0]  instruction bits [14:12]
//     instr30           instruction bit 30 (SUB/SRA qualifier)
//     OpControl  [10:0] registered one-hot ALU operation select
//   Modports:
//     master : drives the decode inputs, observes OpControl (decoder / bench)
//     slave  : consumes the decode inputs, drives OpControl (alu_controller)
interface alu_controller_if;
  logic [4:0]  ALUControl;
  logic [2:0]  func3;
  logic        instr30;
  logic [10:0] OpControl;

  modport master (
    output ALUControl,
    output func3,
    output instr30,
    input  OpControl
  );

  modport slave (
    input  ALUControl,
    input  func3,
    input  instr30,
    output OpControl
  );
endinterface

// File: rtl/alu_controller.sv
// alu_controller
//   Translates the main decoder's instruction-class select plus func3 and
//   instruction bit 30 into a one-hot ALU operation select. The decode is
//   purely combinational and is captured in a single output register, so
//   OpControl reflects the inputs sampled at the previous rising edge.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (clears OpControl)
//     bus  : alu_controller_if.slave
//            in : ALUControl[4:0], func3[2:0], instr30
//            out: OpControl[10:0]
//   OpControl bit map:
//     [0] ADD  [1] SUB  [2] SLL  [3] SLT  [4] SLTU  [5] XOR
//     [6] SRL  [7] SRA  [8] OR   [9] AND  [10] PASSB
module alu_controller (
  input  logic              clk,
  input  logic              rst,
  alu_controller_if.slave   bus
);

  localparam int OP_W = 11;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLL   = 2;
  localparam int OP_SLT   = 3;
  localparam int OP_SLTU  = 4;
  localparam int OP_XOR   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_OR    = 8;
  localparam int OP_AND   = 9;
  localparam int OP_PASSB = 10;

  // Instruction-class encodings from the main decoder.
  localparam logic [4:0] CLS_ADDR   = 5'b00000;
  localparam logic [4:0] CLS_RTYPE  = 5'b00001;
  localparam logic [4:0] CLS_ITYPE  = 5'b00010;
  localparam logic [4:0] CLS_BRANCH = 5'b00100;
  localparam logic [4:0] CLS_LUI    = 5'b01000;
  localparam logic [4:0] CLS_JUMP   = 5'b10000;

  logic [OP_W-1:0] op_control_reg;
  logic [OP_W-1:0] op_control_next;

  // Shared register-register / register-immediate func3 decode.
  // allow_sub selects whether instr30 may turn ADD into SUB (false for
  // ADDI, since there is no SUBI). instr30 only matters at 000 and 101.
  function automatic logic [OP_W-1:0] arith_decode(
    input logic [2:0] f3,
    input logic       i30,
    input logic       allow_sub
  );
    logic [OP_W-1:0] op;
    op = '0;
    case (f3)
      3'b000: op[(allow_sub && i30) ? OP_SUB : OP_ADD] = 1'b1;
      3'b001: op[OP_SLL]  = 1'b1;
      3'b010: op[OP_SLT]  = 1'b1;
      3'b011: op[OP_SLTU] = 1'b1;
      3'b100: op[OP_XOR]  = 1'b1;
      3'b101: op[i30 ? OP_SRA : OP_SRL] = 1'b1;
      3'b110: op[OP_OR]   = 1'b1;
      default: op[OP_AND] = 1'b1;
    endcase
    return op;
  endfunction

  // Branches compare via SUB (equality), SLT (signed) or SLTU (unsigned);
  // func3 010/011 are not branch encodings and produce no operation.
  function automatic logic [OP_W-1:0] branch_decode(input logic [2:0] f3);
    logic [OP_W-1:0] op;
    op = '0;
    case (f3[2:1])
      2'b00:   op[OP_SUB]  = 1'b1;
      2'b10:   op[OP_SLT]  = 1'b1;
      2'b11:   op[OP_SLTU] = 1'b1;
      default: op          = '0;
    endcase
    return op;
  endfunction

  always_comb begin
    op_control_next = '0;
    // Anything that is neither zero nor one-hot falls to the default
    // and yields an all-zero select.
    case (bus.ALUControl)
      CLS_ADDR:   op_control_next[OP_ADD]   = 1'b1;
      CLS_RTYPE:  op_control_next = arith_decode(bus.func3, bus.instr30, 1'b1);
      CLS_ITYPE:  op_control_next = arith_decode(bus.func3, bus.instr30, 1'b0);
      CLS_BRANCH: op_control_next = branch_decode(bus.func3);
      CLS_LUI:    op_control_next[OP_PASSB] = 1'b1;
      CLS_JUMP:   op_control_next[OP_ADD]   = 1'b1;
      default:    op_control_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_control_reg <= '0;
    end else begin
      op_control_reg <= op_control_next;
    end
  end

  assign bus.OpControl = op_control_reg;

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller
//   Drives directed decode vectors into alu_controller through the
//   interface, queueing the hand-computed expected OpControl for each one.
//   A separate monitor pops one entry per clock (just after the edge that
//   registers it) and compares, also checking the one-hot-or-zero and
//   no-X properties on every registered value.
module tb_alu_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_controller_if bus ();

  alu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [10:0] exp;
    bit          chk;   // 0: only the one-hot/no-X property is checked
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Apply one set of inputs at the falling edge; it is registered at the
  // next rising edge and checked by the monitor right after that edge.
  task automatic drive(input logic r, input logic [4:0] ac, input logic [2:0] f3,
                       input logic i30, input logic [10:0] e, input bit chk,
                       input string tag);
    exp_t t;
    @(negedge clk);
    rst            = r;
    bus.ALUControl = ac;
    bus.func3      = f3;
    bus.instr30    = i30;
    t.exp = e;
    t.chk = chk;
    t.tag = tag;
    sb.push_back(t);
  endtask

  // Monitor: the output is valid every cycle, one queued entry per edge.
  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        n_checks++;
        if ($isunknown(bus.OpControl) || !$onehot0(bus.OpControl)) begin
          n_fail++;
          $display("FAIL %s onehot0: OpControl=%h is not one-hot-or-zero", t.tag, bus.OpControl);
        end
        if (t.chk) begin
          n_checks++;
          if (bus.OpControl !== t.exp) begin
            n_fail++;
            $display("FAIL %s: OpControl=%h expected=%h", t.tag, bus.OpControl, t.exp);
          end else begin
            $display("txn %s: OpControl=%h expected=%h ok", t.tag, bus.OpControl, t.exp);
          end
        end
      end
    end
  end

  logic [10:0] rexp[8] = '{11'h002, 11'h004, 11'h008, 11'h010,
                           11'h020, 11'h080, 11'h100, 11'h200};
  logic [10:0] bexp[8] = '{11'h002, 11'h002, 11'h000, 11'h000,
                           11'h008, 11'h008, 11'h010, 11'h010};

  initial begin : stim
    logic [4:0]  ac;
    logic [2:0]  f3;
    logic        i30;
    logic [10:0] e;
    bit          c;
    int          guard;

    rst            = 1'b1;
    bus.ALUControl = 5'b00001;
    bus.func3      = 3'b000;
    bus.instr30    = 1'b0;

    // Reset held two edges with R-type ADD inputs, then released.
    drive(1'b1, 5'b00001, 3'b000, 1'b0, 11'h000, 1'b1, "reset_edge1");
    drive(1'b1, 5'b00001, 3'b000, 1'b0, 11'h000, 1'b1, "reset_edge2");
    drive(1'b0, 5'b00001, 3'b000, 1'b0, 11'h001, 1'b1, "reset_release_add");

    // R-type sweep with instr30=1.
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      drive(1'b0, 5'b00001, f3, 1'b1, rexp[i], 1'b1, $sformatf("rtype_i30_f3_%0d", i));
    end
    // instr30 ignored away from 000/101; at 101 with instr30=0 -> SRL.
    drive(1'b0, 5'b00001, 3'b101, 1'b0, 11'h040, 1'b1, "rtype_srl");
    drive(1'b0, 5'b00001, 3'b111, 1'b0, 11'h200, 1'b1, "rtype_and_i30_0");

    // I-type.
    drive(1'b0, 5'b00010, 3'b000, 1'b1, 11'h001, 1'b1, "itype_addi_i30");
    drive(1'b0, 5'b00010, 3'b101, 1'b1, 11'h080, 1'b1, "itype_srai");
    drive(1'b0, 5'b00010, 3'b101, 1'b0, 11'h040, 1'b1, "itype_srli");
    drive(1'b0, 5'b00010, 3'b011, 1'b1, 11'h010, 1'b1, "itype_sltiu");

    // Branch compare, all func3.
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      drive(1'b0, 5'b00100, f3, 1'(i & 1), bexp[i], 1'b1, $sformatf("branch_f3_%0d", i));
    end

    // Fixed classes across all 16 func3/instr30 combinations.
    for (int k = 0; k < 16; k++) begin
      f3  = 3'(k >> 1);
      i30 = 1'(k);
      drive(1'b0, 5'b00000, f3, i30, 11'h001, 1'b1, $sformatf("addr_k%0d", k));
      drive(1'b0, 5'b10000, f3, i30, 11'h001, 1'b1, $sformatf("jump_k%0d", k));
      drive(1'b0, 5'b01000, f3, i30, 11'h400, 1'b1, $sformatf("lui_k%0d", k));
    end

    // Illegal class selects.
    drive(1'b0, 5'b00011, 3'b000, 1'b0, 11'h000, 1'b1, "illegal_00011");
    drive(1'b0, 5'b11111, 3'b101, 1'b1, 11'h000, 1'b1, "illegal_11111");

    // Mid-stream reset discards the pending decode.
    drive(1'b0, 5'b00100, 3'b000, 1'b0, 11'h002, 1'b1, "pre_reset_sub");
    drive(1'b1, 5'b01000, 3'b000, 1'b0, 11'h000, 1'b1, "midstream_reset");
    drive(1'b0, 5'b01000, 3'b000, 1'b0, 11'h400, 1'b1, "post_reset_passb");

    // Exhaustive sweep: property on every cycle, values where the class
    // fixes the answer independently of func3/instr30.
    for (int a = 0; a < 32; a++) begin
      for (int f = 0; f < 8; f++) begin
        for (int b = 0; b < 2; b++) begin
          ac  = 5'(a);
          f3  = 3'(f);
          i30 = 1'(b);
          c   = 1'b1;
          if (ac == 5'b00000 || ac == 5'b10000)      e = 11'h001;
          else if (ac == 5'b01000)                   e = 11'h400;
          else if (!$onehot(ac))                     e = 11'h000;
          else begin e = 11'h000; c = 1'b0; end
          drive(1'b0, ac, f3, i30, e, c, $sformatf("sweep_%02h_%0d_%0d", a, f, b));
        end
      end
    end

    // Let the monitor drain the queue, bounded.
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
